wb_writeback_unit: RTL and testbench
====================================

Name: wb_writeback_unit

Overview:
Consumer end of the MEM/WB pipeline interface. It takes the registered MEM/WB bundle (memory word, memory byte, ALU result, control bits, destination register) and commits the selected result to the scalar register bank and the vector register bank. Byte results bound for vector registers are packed four at a time into a 32-bit vector word before commit. The block provides combinational read ports for the decode stage.

Parameters:
DW, 32, data word width (fixed; byte lanes are DW/4 = 8 bits)
NREG, 16, entries per bank (scalar and vector)
AW, 4, register address width (log2 NREG)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
Do  in  32  memory word from MEM/WB
Dob  in  8  memory byte from MEM/WB
ALU_Result  in  32  ALU result from MEM/WB
WE_C  in  1  scalar bank write enable
WE_V  in  1  vector bank write enable
SEL_C  in  1  1 = byte result, 0 = word result
SEL_DAT  in  1  1 = memory data, 0 = ALU data
PROHIB_WB  in  1  squash; 1 suppresses all writes this cycle
Rg  in  4  destination register
ra_a, ra_b  in  4  scalar read addresses
ra_v  in  4  vector read address
rd_a, rd_b  out  32  scalar read data
rd_v  out  32  vector read data
wb_valid  out  1  1-cycle pulse: a bank write committed
wb_data  out  32  value committed (scalar value if WE_C, else vector word)
pack_busy  out  1  packer holds partial bytes
pack_lanes  out  2  number of bytes held (0-3)
pack_err  out  1  1-cycle pulse: partial pack discarded

Behaviour:
- Reset (rst_n=0, async): both banks cleared to 0; packer in IDLE; lanes=0; wb_valid=0; wb_data=0; pack_err=0.
- Result selection: word = SEL_DAT ? Do : ALU_Result; byte = SEL_DAT ? Dob : ALU_Result[7:0]; scalar value = SEL_C ? {24'b0, byte} : word.
- Commit is qualified by !PROHIB_WB. The write occurs at the posedge where the inputs are present and is visible on the read ports after that edge (zero-cycle write latency, one-cycle read-after-write without bypass).
- Scalar bank: R0 reads 0 always; writes to R0 are dropped, with no wb_valid for the scalar part.
- Vector word path (WE_V & !SEL_C): vreg[Rg] <= word directly.
- Vector byte path (WE_V & SEL_C): packer FSM, states IDLE, LANE1, LANE2, LANE3 (bytes held); target register tgt and 24-bit buffer.
  - IDLE: tgt<=Rg, buf[7:0]<=byte, go LANE1.
  - LANEn, Rg==tgt: the byte goes into bits 8n+7:8n. In LANE3 the block commits vreg[tgt] <= {byte, buf[23:0]}, pulses wb_valid, and goes to IDLE. Otherwise it goes to LANEn+1.
  - LANEn, Rg!=tgt: pulse pack_err, discard the buffer, restart (tgt<=Rg, byte into lane 0, go LANE1).
- Vector word write to Rg==tgt while packing: pack_err, buffer discarded, packer goes to IDLE, and the word write proceeds. A word write to a different Rg proceeds and the packer holds.
- PROHIB_WB=1 or WE_V=0: packer holds state; no pack_err.
- WE_C and WE_V both 1: both banks are written in the same cycle. A byte-packed vector commit and a scalar write coexist; wb_data carries the scalar value.
- pack_busy = (state!=IDLE); pack_lanes = state encoding.
- rd_a/rd_b/rd_v are combinational array reads.
- Reset mid-pack discards the partial word without pulsing pack_err.

Optional Feature:
WB_BYPASS_EN: when defined, rd_a/rd_b return the scalar value being committed this cycle whenever the read address equals Rg, WE_C=1, PROHIB_WB=0 and Rg!=0 (write-through; R0 is still 0). Vector reads are not bypassed. When undefined, reads return array contents only, and a new value appears the cycle after commit.

Test Plan:
- Reset, then WE_C=1, SEL_C=0, SEL_DAT=0, ALU_Result=32'hDEADBEEF, Rg=5 -> next cycle ra_a=5 gives rd_a=32'hDEADBEEF; wb_valid pulses once.
- Same write with Rg=0 -> rd_a at addr 0 stays 0; no wb_valid. Same write with PROHIB_WB=1, Rg=7 -> R7 stays 0.
- WE_V=1, SEL_C=1, SEL_DAT=1, Rg=3, Dob=11,22,33,44 on consecutive cycles -> pack_lanes 1,2,3, then rd_v(3)=32'h44332211, wb_valid on the 4th cycle, pack_busy=0.
- Two bytes to Rg=3, then byte 8'hAA to Rg=4 -> pack_err pulse, vreg3 unchanged, pack_lanes=1, tgt=4; three more bytes to Rg=4 -> commit with lane0=AA.
- Packing Rg=2 (2 bytes), PROHIB_WB=1 byte in between -> state held; assert rst_n low mid-pack -> lanes=0, banks zero, no pack_err.
- With WB_BYPASS_EN: WE_C write of 32'h12345678 to R9 with ra_b=9 in the same cycle -> rd_b=32'h12345678 that cycle. Without the macro -> rd_b shows the old value (0) that cycle and the new value next cycle.

Source files
------------

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB bundle consumed by the writeback unit.
// The pipeline register drives it through the master modport.
// The writeback unit reads it through the slave modport.
interface wb_writeback_unit_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic [DW-1:0]   Do;
  logic [DW/4-1:0] Dob;
  logic [DW-1:0]   ALU_Result;
  logic            WE_C;
  logic            WE_V;
  logic            SEL_C;
  logic            SEL_DAT;
  logic            PROHIB_WB;
  logic [AW-1:0]   Rg;

  modport master (
    output Do, Dob, ALU_Result, WE_C, WE_V, SEL_C, SEL_DAT, PROHIB_WB, Rg
  );

  modport slave (
    input  Do, Dob, ALU_Result, WE_C, WE_V, SEL_C, SEL_DAT, PROHIB_WB, Rg
  );
endinterface

// File: rtl/wb_writeback_unit.sv
// Writeback stage: commits the MEM/WB result to the scalar and vector
// register banks. Byte results bound for the vector bank are packed four
// at a time into one word before commit. Read ports are combinational.
// Optional macro WB_BYPASS_EN: scalar reads see the value being committed
// in the same cycle (write-through). R0 stays 0, and vector reads are not
// bypassed.
module wb_writeback_unit #(
  parameter int DW   = 32,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_writeback_unit_if.slave  mw,
  input  logic [AW-1:0]       ra_a,
  input  logic [AW-1:0]       ra_b,
  input  logic [AW-1:0]       ra_v,
  output logic [DW-1:0]       rd_a,
  output logic [DW-1:0]       rd_b,
  output logic [DW-1:0]       rd_v,
  output logic                wb_valid,
  output logic [DW-1:0]       wb_data,
  output logic                pack_busy,
  output logic [1:0]          pack_lanes,
  output logic                pack_err
);

  localparam int BW = DW / 4;

  // The state encoding doubles as the number of bytes held.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  logic [DW-1:0]   sreg_q [NREG];
  logic [DW-1:0]   vreg_q [NREG];
  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   tgt_q, tgt_d;
  logic [3*BW-1:0] buf_q, buf_d;
  logic            wb_valid_q, wb_valid_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic            pack_err_q, pack_err_d;

  logic [DW-1:0] word_v, sval_v;
  logic [BW-1:0] byte_v;
  logic          s_we, vw_we, vb_we, busy, hit, pk_commit;

  // Select the result and qualify every write with the squash bit.
  always_comb begin
    word_v = mw.SEL_DAT ? mw.Do : mw.ALU_Result;
    byte_v = mw.SEL_DAT ? mw.Dob : mw.ALU_Result[BW-1:0];
    sval_v = mw.SEL_C ? {{(DW-BW){1'b0}}, byte_v} : word_v;
    s_we   = !mw.PROHIB_WB && mw.WE_C && (mw.Rg != '0);
    vw_we  = !mw.PROHIB_WB && mw.WE_V && !mw.SEL_C;
    vb_we  = !mw.PROHIB_WB && mw.WE_V && mw.SEL_C;
    busy   = (state_q != IDLE);
    hit    = (mw.Rg == tgt_q);
  end

  // Packer next state. A word write to the pack target, or a byte that
  // targets another register, throws the partial word away.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    buf_d      = buf_q;
    pack_err_d = 1'b0;
    pk_commit  = 1'b0;
    if (vw_we && busy && hit) begin
      pack_err_d = 1'b1;
      state_d    = IDLE;
      buf_d      = '0;
    end else if (vb_we) begin
      if (!busy || !hit) begin
        pack_err_d = busy;
        tgt_d      = mw.Rg;
        buf_d      = {{(2*BW){1'b0}}, byte_v};
        state_d    = LANE1;
      end else begin
        case (state_q)
          LANE1: begin
            buf_d[2*BW-1:BW] = byte_v;
            state_d          = LANE2;
          end
          LANE2: begin
            buf_d[3*BW-1:2*BW] = byte_v;
            state_d            = LANE3;
          end
          default: begin
            pk_commit = 1'b1;
            buf_d     = '0;
            state_d   = IDLE;
          end
        endcase
      end
    end
  end

  // Commit status. wb_data prefers the scalar value when both banks write.
  always_comb begin
    wb_valid_d = s_we || vw_we || pk_commit;
    if (s_we)           wb_data_d = sval_v;
    else if (vw_we)     wb_data_d = word_v;
    else if (pk_commit) wb_data_d = {byte_v, buf_q};
    else                wb_data_d = wb_data_q;
  end

  // Register banks. R0 is never written, so it always reads back as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        sreg_q[i] <= '0;
        vreg_q[i] <= '0;
      end
    end else begin
      if (s_we)           sreg_q[mw.Rg] <= sval_v;
      if (vw_we)          vreg_q[mw.Rg] <= word_v;
      else if (pk_commit) vreg_q[tgt_q] <= {byte_v, buf_q};
    end
  end

  // Packer state and the commit/error status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      buf_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      pack_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      buf_q      <= buf_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      pack_err_q <= pack_err_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign rd_a = (s_we && (ra_a == mw.Rg)) ? sval_v : sreg_q[ra_a];
  assign rd_b = (s_we && (ra_b == mw.Rg)) ? sval_v : sreg_q[ra_b];
`else
  assign rd_a = sreg_q[ra_a];
  assign rd_b = sreg_q[ra_b];
`endif
  assign rd_v       = vreg_q[ra_v];
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign pack_err   = pack_err_q;
  assign pack_busy  = busy;
  assign pack_lanes = state_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit: a vector table plus hand-written
// sequences for squash/hold, reset mid-pack and same-cycle read of a write.
module tb_wb_writeback_unit;

  localparam logic [4:0] C_WEC = 5'b10000;
  localparam logic [4:0] C_WEV = 5'b01000;
  localparam logic [4:0] C_SLC = 5'b00100;
  localparam logic [4:0] C_SLD = 5'b00010;
  localparam logic [4:0] C_PRO = 5'b00001;

  typedef struct {
    logic [31:0] d;
    logic [31:0] alu;
    logic [7:0]  b;
    logic [4:0]  ctl;
    logic [3:0]  rg;
    logic [3:0]  ra;
    logic [31:0] e_rda;
    logic [31:0] e_rdv;
    logic [31:0] e_wbd;
    logic        e_vld;
    logic [1:0]  e_lanes;
    logic        e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ra_a = '0, ra_b = '0, ra_v = '0;
  logic [31:0] rd_a, rd_b, rd_v, wb_data;
  logic        wb_valid, pack_busy, pack_err;
  logic [1:0]  pack_lanes;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  wb_writeback_unit_if mw ();

  wb_writeback_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mw         (mw.slave),
    .ra_a       (ra_a),
    .ra_b       (ra_b),
    .ra_v       (ra_v),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .rd_v       (rd_v),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .pack_busy  (pack_busy),
    .pack_lanes (pack_lanes),
    .pack_err   (pack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] alu, input logic [7:0] b,
                       input logic [4:0] ctl, input logic [3:0] rg);
    mw.Do         = d;
    mw.ALU_Result = alu;
    mw.Dob        = b;
    mw.WE_C       = ctl[4];
    mw.WE_V       = ctl[3];
    mw.SEL_C      = ctl[2];
    mw.SEL_DAT    = ctl[1];
    mw.PROHIB_WB  = ctl[0];
    mw.Rg         = rg;
  endtask

  function automatic vec_t mkv(input logic [31:0] d, input logic [31:0] alu, input logic [7:0] b,
                               input logic [4:0] ctl, input logic [3:0] rg, input logic [3:0] ra,
                               input logic [31:0] e_rda, input logic [31:0] e_rdv,
                               input logic [31:0] e_wbd, input logic e_vld,
                               input logic [1:0] e_lanes, input logic e_err);
    vec_t v;
    v.d = d; v.alu = alu; v.b = b; v.ctl = ctl; v.rg = rg; v.ra = ra;
    v.e_rda = e_rda; v.e_rdv = e_rdv; v.e_wbd = e_wbd; v.e_vld = e_vld;
    v.e_lanes = e_lanes; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    logic [4:0] wb;   // vector byte write from memory
    logic [4:0] ww;   // vector word write from ALU
    wb = C_WEV | C_SLC | C_SLD;
    ww = C_WEV;

    // Scalar writes
    tbl.push_back(mkv(0, 32'hDEADBEEF, 0, C_WEC, 5, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 32'hDEADBEEF, 0, C_WEC, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 32'hDEADBEEF, 0, C_WEC | C_PRO, 7, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 32'h123456AB, 8'h77, C_WEC | C_SLC, 6, 6, 32'h000000AB, 0, 32'h000000AB, 1, 0, 0));
    tbl.push_back(mkv(32'hCAFEF00D, 0, 0, C_WEC | C_SLD, 6, 6, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 0, 0));
    // Four bytes packed into V3
    tbl.push_back(mkv(0, 0, 8'h11, wb, 3, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 0, 8'h22, wb, 3, 3, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(0, 0, 8'h33, wb, 3, 3, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mkv(0, 0, 8'h44, wb, 3, 3, 0, 32'h44332211, 32'h44332211, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 3, 0, 32'h44332211, 0, 0, 0, 0));
    // Target switch mid-pack, then complete on V4
    tbl.push_back(mkv(0, 0, 8'h55, wb, 3, 3, 0, 32'h44332211, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 0, 8'h66, wb, 3, 3, 0, 32'h44332211, 0, 0, 2, 0));
    tbl.push_back(mkv(0, 0, 8'hAA, wb, 4, 3, 0, 32'h44332211, 0, 0, 1, 1));
    tbl.push_back(mkv(0, 0, 8'hBB, wb, 4, 4, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(0, 0, 8'hCC, wb, 4, 4, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mkv(0, 0, 8'hDD, wb, 4, 4, 0, 32'hDDCCBBAA, 32'hDDCCBBAA, 1, 0, 0));
    // Vector word path
    tbl.push_back(mkv(0, 32'h0BADF00D, 0, ww, 8, 8, 0, 32'h0BADF00D, 32'h0BADF00D, 1, 0, 0));
    // Word write to the pack target aborts the pack
    tbl.push_back(mkv(0, 0, 8'h01, wb, 9, 9, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 32'h11112222, 0, ww, 9, 9, 0, 32'h11112222, 32'h11112222, 1, 0, 1));
    // Word write elsewhere leaves the pack alone
    tbl.push_back(mkv(0, 0, 8'h01, wb, 10, 10, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 32'h33334444, 0, ww, 11, 11, 0, 32'h33334444, 32'h33334444, 1, 1, 0));
    tbl.push_back(mkv(0, 0, 8'h02, wb, 10, 10, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(0, 0, 8'h03, wb, 10, 10, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mkv(0, 0, 8'h04, wb, 10, 10, 0, 32'h04030201, 32'h04030201, 1, 0, 0));
    // Both banks in one cycle
    tbl.push_back(mkv(0, 32'h5A5A5A5A, 0, C_WEC | C_WEV, 13, 13, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 1, 0, 0));

    drive(0, 0, 0, 0, 0);
    ra_a = 4'd5; ra_v = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_lanes", {30'b0, pack_lanes}, 0);
    check("reset_busy", {31'b0, pack_busy}, 0);
    check("reset_valid", {31'b0, wb_valid}, 0);
    check("reset_wbdata", wb_data, 0);
    check("reset_err", {31'b0, pack_err}, 0);
    check("reset_rda", rd_a, 0);
    check("reset_rdv", rd_v, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].d, tbl[i].alu, tbl[i].b, tbl[i].ctl, tbl[i].rg);
      ra_a = tbl[i].ra; ra_v = tbl[i].ra;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rda", i), rd_a, tbl[i].e_rda);
      check($sformatf("v%0d_rdv", i), rd_v, tbl[i].e_rdv);
      check($sformatf("v%0d_valid", i), {31'b0, wb_valid}, {31'b0, tbl[i].e_vld});
      check($sformatf("v%0d_lanes", i), {30'b0, pack_lanes}, {30'b0, tbl[i].e_lanes});
      check($sformatf("v%0d_busy", i), {31'b0, pack_busy}, {31'b0, (tbl[i].e_lanes != 2'd0)});
      check($sformatf("v%0d_err", i), {31'b0, pack_err}, {31'b0, tbl[i].e_err});
      if (tbl[i].e_vld) check($sformatf("v%0d_wbdata", i), wb_data, tbl[i].e_wbd);
    end

    // Squash and WE_V=0 hold the packer; reset mid-pack then clears it
    @(negedge clk);
    drive(0, 0, 8'h10, wb, 2);
    @(negedge clk);
    drive(0, 0, 8'h20, wb, 2);
    @(negedge clk);
    drive(0, 0, 8'h30, wb | C_PRO, 2);
    @(posedge clk); #1;
    check("hold_prohib_lanes", {30'b0, pack_lanes}, 2);
    check("hold_prohib_err", {31'b0, pack_err}, 0);
    @(negedge clk);
    drive(0, 0, 8'h30, C_SLC | C_SLD, 2);
    @(posedge clk); #1;
    check("hold_wev0_lanes", {30'b0, pack_lanes}, 2);
    check("hold_wev0_err", {31'b0, pack_err}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    ra_a = 4'd6; ra_v = 4'd3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_lanes", {30'b0, pack_lanes}, 0);
    check("rst_mid_busy", {31'b0, pack_busy}, 0);
    check("rst_mid_err", {31'b0, pack_err}, 0);
    check("rst_mid_sbank", rd_a, 0);
    check("rst_mid_vbank", rd_v, 0);
    check("rst_mid_wbdata", wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_err", {31'b0, pack_err}, 0);
    check("post_rst_lanes", {30'b0, pack_lanes}, 0);

    // Same-cycle read of a scalar being written
    @(negedge clk);
    drive(0, 32'h12345678, 0, C_WEC, 9);
    ra_b = 4'd9;
    #1;
`ifdef WB_BYPASS_EN
    check("same_cycle_rdb", rd_b, 32'h12345678);
`else
    check("same_cycle_rdb", rd_b, 0);
`endif
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    #1;
    check("next_cycle_rdb", rd_b, 32'h12345678);
    check("next_cycle_valid", {31'b0, wb_valid}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
